pmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single physical-memory (cacheline adaptor) port between the pipelined I-cache and the D-cache. Each cache's miss/writeback request is accepted in turn, its address and write data are captured, and exactly one line transfer is issued to memory at a time. The response is routed back to the granted cache only. The block sits between the two cache controllers' pmem ports and the cacheline adaptor.

---
 rtl/pmem_arbiter_pkg.sv | 19 +
 rtl/pmem_arbiter.sv | 120 ++++++++++++
 tb/tb_pmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D cache physical-memory arbiter.
// Holds the arbiter state encoding, the round-robin grant marker and default widths.
package pmem_arbiter_pkg;

  localparam int PMEM_ADDR_W = 32;
  localparam int PMEM_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one cacheline-adaptor port between the I-cache and D-cache.
// One transfer at a time; memory sees only captured registers while a transfer is in flight.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int LINE_W = PMEM_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t  state_q, state_d;
  arb_grant_t  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic read_q, read_d;
  logic write_q, write_d;
  logic i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    write_d      = write_q;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // I wins when alone, or on a tie when D had the previous grant.
        if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
          addr_d       = i_pmem_address;
          read_d       = 1'b1;
          write_d      = 1'b0;
          last_grant_d = GRANT_I;
          state_d      = SERVE_I;
        end else if (d_req) begin
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
          write_d      = d_pmem_write;
          read_d       = ~d_pmem_write;
          last_grant_d = GRANT_D;
          state_d      = SERVE_D;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_pmem_resp = 1'b1;
          read_d      = 1'b0;
          write_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_pmem_resp = 1'b1;
          read_d      = 1'b0;
          write_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // A D-cache read and writeback together is a controller bug; the write is served.
  a_no_d_read_write : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter: lone misses, ties, round-robin,
// writeback capture, spurious/withdrawn requests and asynchronous reset mid-transfer.
module tb_pmem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int vector_count = 0;
  int miss_count   = 0;

  localparam logic [255:0] LINE_A5   = {32{8'hA5}};
  localparam logic [255:0] LINE_DEAD = {8{32'hDEADBEEF}};
  localparam logic [255:0] LINE_5A   = {32{8'h5A}};

  pmem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da,
                               input logic [255:0] dwd);
    i_pmem_read    = ir;
    i_pmem_address = ia;
    d_pmem_read    = dr;
    d_pmem_write   = dw;
    d_pmem_address = da;
    d_pmem_wdata   = dwd;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    rst_n      = 1'b0;
    repeat (2) nextCycle();
    rst_n = 1'b1;
  endtask

  task automatic waitGrant(output int waited);
    waited = 0;
    while (!(pmem_read || pmem_write) && waited < 8) begin
      nextCycle();
      waited++;
    end
    if (!(pmem_read || pmem_write)) checkOutput("grant_timeout", 256'd0, 256'd1);
  endtask

  task automatic serveOne(input bit owner_d, input logic [31:0] exp_addr,
                          input int latency, input logic [255:0] line);
    int waited;
    waitGrant(waited);
    checkOutput("rr_gap", 256'(waited), 256'd1);
    checkOutput(owner_d ? "rr_d_addr" : "rr_i_addr", 256'(pmem_address), 256'(exp_addr));
    checkOutput("rr_read", 256'(pmem_read), 256'd1);
    repeat (latency - 1) nextCycle();
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    #1;
    checkOutput("rr_i_resp", 256'(i_pmem_resp), 256'(!owner_d));
    checkOutput("rr_d_resp", 256'(d_pmem_resp), 256'(owner_d));
    checkOutput("rr_rdata", owner_d ? d_pmem_rdata : i_pmem_rdata, line);
    nextCycle();
    pmem_resp = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #2;
    checkOutput("rst_read", 256'(pmem_read), 256'd0);
    checkOutput("rst_write", 256'(pmem_write), 256'd0);
    checkOutput("rst_addr", 256'(pmem_address), 256'd0);
    checkOutput("rst_wdata", pmem_wdata, 256'd0);
    checkOutput("rst_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
    repeat (2) nextCycle();
    rst_n = 1'b1;

    // Lone I miss, memory answers in cycle 5.
    nextCycle();
    applyStimulus(1'b1, 32'h0000_1040, 1'b0, 1'b0, 32'h0, '0);
    #1;
    checkOutput("lone_c0_read", 256'(pmem_read), 256'd0);
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      if (c == 5) begin
        pmem_rdata = LINE_A5;
        pmem_resp  = 1'b1;
      end
      #1;
      checkOutput("lone_read", 256'(pmem_read), 256'd1);
      checkOutput("lone_addr", 256'(pmem_address), 256'h1040);
      checkOutput("lone_i_resp", 256'(i_pmem_resp), 256'(c == 5));
      checkOutput("lone_d_resp", 256'(d_pmem_resp), 256'd0);
    end
    checkOutput("lone_rdata", i_pmem_rdata, LINE_A5);
    nextCycle();
    pmem_resp = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    checkOutput("lone_c6_read", 256'(pmem_read), 256'd0);
    checkOutput("lone_c6_resp", 256'(i_pmem_resp), 256'd0);

    // Tie after reset: I first, then D at k+2.
    doReset();
    nextCycle();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0);
    nextCycle();
    checkOutput("tie_first_addr", 256'(pmem_address), 256'h100);
    nextCycle();
    pmem_rdata = LINE_5A;
    pmem_resp  = 1'b1;
    #1;
    checkOutput("tie_i_resp", 256'(i_pmem_resp), 256'd1);
    checkOutput("tie_d_quiet", 256'(d_pmem_resp), 256'd0);
    nextCycle();
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    checkOutput("tie_k1_idle", 256'({pmem_read, pmem_write}), 256'd0);
    nextCycle();
    checkOutput("tie_k2_addr", 256'(pmem_address), 256'h200);
    checkOutput("tie_k2_read", 256'(pmem_read), 256'd1);
    nextCycle();
    pmem_resp = 1'b1;
    #1;
    checkOutput("tie_d_resp", 256'(d_pmem_resp), 256'd1);
    checkOutput("tie_i_quiet", 256'(i_pmem_resp), 256'd0);
    nextCycle();
    pmem_resp = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    nextCycle();

    // Continuous contention: last grant was D, so order is I, D, I, D, I, D.
    applyStimulus(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_4000, '0);
    for (int t = 0; t < 6; t++) begin
      serveOne(t[0], t[0] ? 32'h0000_4000 : 32'h0000_3000, 2 + (t % 3),
               t[0] ? LINE_5A : LINE_A5);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    nextCycle();

    // D writeback: captured address/data survive requester changes.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0020, LINE_DEAD);
    nextCycle();
    checkOutput("wb_write", 256'(pmem_write), 256'd1);
    checkOutput("wb_no_read", 256'(pmem_read), 256'd0);
    checkOutput("wb_addr", 256'(pmem_address), 256'h8000_0020);
    checkOutput("wb_wdata", pmem_wdata, LINE_DEAD);
    nextCycle();
    d_pmem_address = 32'hFFFF_FFFF;
    d_pmem_wdata   = '0;
    nextCycle();
    checkOutput("wb_addr_held", 256'(pmem_address), 256'h8000_0020);
    checkOutput("wb_wdata_held", pmem_wdata, LINE_DEAD);
    pmem_resp = 1'b1;
    #1;
    checkOutput("wb_d_resp", 256'(d_pmem_resp), 256'd1);
    nextCycle();
    pmem_resp = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    nextCycle();

    // Spurious resp in IDLE, then a withdrawn I request.
    pmem_resp = 1'b1;
    #1;
    checkOutput("spur_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
    nextCycle();
    pmem_resp = 1'b0;
    #1;
    checkOutput("spur_idle", 256'({pmem_read, pmem_write}), 256'd0);
    applyStimulus(1'b1, 32'h0000_5500, 1'b0, 1'b0, 32'h0, '0);
    nextCycle();
    nextCycle();
    i_pmem_read = 1'b0;
    nextCycle();
    checkOutput("wd_read_held", 256'(pmem_read), 256'd1);
    checkOutput("wd_addr_held", 256'(pmem_address), 256'h5500);
    nextCycle();
    pmem_resp = 1'b1;
    #1;
    checkOutput("wd_i_resp", 256'(i_pmem_resp), 256'd1);
    nextCycle();
    pmem_resp = 1'b0;
    #1;
    checkOutput("wd_idle", 256'(pmem_read), 256'd0);

    // Reset asserted mid-SERVE_D while memory is responding.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0600, LINE_A5);
    nextCycle();
    nextCycle();
    pmem_resp = 1'b1;
    #1;
    checkOutput("rmid_pre_resp", 256'(d_pmem_resp), 256'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_write", 256'(pmem_write), 256'd0);
    checkOutput("rmid_addr", 256'(pmem_address), 256'd0);
    checkOutput("rmid_wdata", pmem_wdata, 256'd0);
    checkOutput("rmid_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
    pmem_resp = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rrel_idle", 256'({pmem_read, pmem_write}), 256'd0);
    applyStimulus(1'b1, 32'h0000_0700, 1'b1, 1'b0, 32'h0000_0800, '0);
    nextCycle();
    checkOutput("rrel_tie_addr", 256'(pmem_address), 256'h700);
    checkOutput("rrel_tie_read", 256'(pmem_read), 256'd1);
    pmem_resp = 1'b1;
    #1;
    checkOutput("rrel_i_resp", 256'(i_pmem_resp), 256'd1);
    nextCycle();
    pmem_resp = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    repeat (3) nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
